// File: rtl/pp_mailbox_responder.sv
// -----------------------------------------------------------------------------
// pp_mailbox_responder
//   Fabric-side responder for the HPS parallel-port mailbox. Commands arrive on
//   a 32-bit PIO word framed by a REQ toggle bit. Each command executes against
//   a 16 x 24-bit register file. The result is returned on a 32-bit PIO word
//   whose ACK bit echoes the REQ of the completed command.
//
// Ports
//   clk_clk        in   1   system clock (same clock as the PIO exports)
//   reset_reset_n  in   1   asynchronous active-low reset
//   pp_cmd         in  32   [31] REQ, [30:28] OP, [27:24] ADDR, [23:0] WDATA
//   pp_rsp         out 32   [31] ACK, [30] ERR, [29:24] SEQ, [23:0] RDATA
//   busy           out  1   a command is latched and not yet acknowledged
//   ctrl_word      out 24   continuous copy of register 0
//   done_pulse     out  1   one-cycle pulse in the cycle pp_rsp updates
//
// Opcodes: 0 NOP, 1 WRITE, 2 READ, 3 ADD (mod 2^24), 4 CLEAR (16 cycles),
//          5-7 illegal (ERR=1, RDATA=0).
// -----------------------------------------------------------------------------
module pp_mailbox_responder #(
    parameter logic [23:0] NOP_ID = 24'hA55A01
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [31:0] pp_cmd,
    output logic [31:0] pp_rsp,
    output logic        busy,
    output logic [23:0] ctrl_word,
    output logic        done_pulse
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_CLEAR
    } state_t;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_WRITE = 3'd1;
    localparam logic [2:0] OP_READ  = 3'd2;
    localparam logic [2:0] OP_ADD   = 3'd3;
    localparam logic [2:0] OP_CLEAR = 3'd4;

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_cmd_q;
    logic        r_req;
    logic [2:0]  r_op;
    logic [3:0]  r_addr;
    logic [23:0] r_wdata;
    logic [3:0]  r_clr_idx;
    logic [23:0] r_regs [16];
    logic [31:0] r_rsp;
    logic        r_done;

    logic        w_new_req;
    logic [23:0] w_rd_val;
    logic [23:0] w_sum;
    logic        w_rsp_we;
    logic        w_err;
    logic [23:0] w_rdata;
    logic        w_reg_we;
    logic [3:0]  w_reg_idx;
    logic [23:0] w_reg_wdata;
    logic [31:0] w_rsp_next;

    // A request is pending whenever the registered REQ differs from the ACK we
    // last returned; only sampled in IDLE so an in-flight command is never
    // disturbed and a stale mismatch is picked up on return to IDLE.
    assign w_new_req = (r_state == ST_IDLE) && (r_cmd_q[31] != r_rsp[31]);
    assign w_rd_val  = r_regs[r_addr];
    assign w_sum     = w_rd_val + r_wdata;   // carry out of bit 23 discarded

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_rsp_we     = 1'b0;
        w_err        = 1'b0;
        w_rdata      = '0;
        w_reg_we     = 1'b0;
        w_reg_idx    = r_addr;
        w_reg_wdata  = '0;

        case (r_state)
            ST_IDLE: begin
                if (w_new_req) begin
                    w_state_next = (r_cmd_q[30:28] == OP_CLEAR) ? ST_CLEAR : ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_next = ST_IDLE;
                w_rsp_we     = 1'b1;
                case (r_op)
                    OP_NOP:   w_rdata = NOP_ID;
                    OP_WRITE: begin
                        w_reg_we    = 1'b1;
                        w_reg_wdata = r_wdata;
                        w_rdata     = r_wdata;
                    end
                    OP_READ:  w_rdata = w_rd_val;
                    OP_ADD: begin
                        w_reg_we    = 1'b1;
                        w_reg_wdata = w_sum;
                        w_rdata     = w_sum;
                    end
                    default:  w_err = 1'b1;
                endcase
            end
            ST_CLEAR: begin
                w_reg_we  = 1'b1;
                w_reg_idx = r_clr_idx;
                // Last register is zeroed in the same cycle the response lands.
                if (r_clr_idx == 4'd15) begin
                    w_rsp_we     = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase

        w_rsp_next = {r_req, w_err, r_rsp[29:24] + 6'd1, w_rdata};
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state   <= ST_IDLE;
            r_cmd_q   <= '0;
            r_req     <= 1'b0;
            r_op      <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_clr_idx <= '0;
            r_rsp     <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cmd_q <= pp_cmd;
            r_done  <= w_rsp_we;
            if (w_new_req) begin
                r_req     <= r_cmd_q[31];
                r_op      <= r_cmd_q[30:28];
                r_addr    <= r_cmd_q[27:24];
                r_wdata   <= r_cmd_q[23:0];
                r_clr_idx <= '0;
            end else if (r_state == ST_CLEAR) begin
                r_clr_idx <= r_clr_idx + 4'd1;
            end
            if (w_rsp_we) begin
                r_rsp <= w_rsp_next;
            end
        end
    end

    // NOTE: the register file is reset because ctrl_word and READ results must
    // be zero after reset, and an aborted CLEAR must leave all entries at zero.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_reg_we) begin
            r_regs[w_reg_idx] <= w_reg_wdata;
        end
    end

    assign pp_rsp     = r_rsp;
    assign busy       = (r_state != ST_IDLE);
    assign ctrl_word  = r_regs[0];
    assign done_pulse = r_done;

endmodule
